// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// controller states and default sizing.
package muldiv_pkg;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_MUL_STAGES = 2;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

endpackage

// File: rtl/div_core.sv
// Radix-2 restoring divider on operand magnitudes, one quotient bit per step,
// with sign correction and divide-by-zero results applied on the outputs.
module div_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] quo_o,
    output logic [WIDTH-1:0] rem_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, quo_q, dvs_q, a_q;
    logic             negq_q, negr_q, dz_q;
    logic [CW-1:0]    cnt_q;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] st_rem, st_quo, st_dvs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] rem_d, quo_d;

    assign a_neg = signed_i & a_i[WIDTH-1];
    assign b_neg = signed_i & b_i[WIDTH-1];
    assign mag_a = a_neg ? -a_i : a_i;
    assign mag_b = b_neg ? -b_i : b_i;

    // The loading edge already retires the first quotient bit.
    always_comb begin
        st_rem  = load_i ? '0 : rem_q;
        st_quo  = load_i ? mag_a : quo_q;
        st_dvs  = load_i ? mag_b : dvs_q;
        shifted = {st_rem, st_quo[WIDTH-1]};
        rem_d   = shifted[WIDTH-1:0];
        quo_d   = {st_quo[WIDTH-2:0], 1'b0};
        if (shifted >= {1'b0, st_dvs}) begin
            rem_d    = WIDTH'(shifted - {1'b0, st_dvs});
            quo_d[0] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            a_q    <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            dz_q   <= 1'b0;
            cnt_q  <= '0;
        end else if (load_i) begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= mag_b;
            a_q    <= a_i;
            negq_q <= a_neg ^ b_neg;
            negr_q <= a_neg;
            dz_q   <= (b_i == '0);
            cnt_q  <= CW'(1);
        end else if (step_i) begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_q + CW'(1);
        end
    end

    assign last_o = (cnt_q == CW'(WIDTH - 1));
    assign quo_o  = dz_q ? '1  : (negq_q ? -quo_q : quo_q);
    assign rem_o  = dz_q ? a_q : (negr_q ? -rem_q : rem_q);

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: controller, multiply pipeline and HI/LO registers.
// Optional MULDIV_EARLY_OUT_EN finishes divisions with |a| < |b| in one cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int MUL_STAGES = DEF_MUL_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cancel_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [1:0]       dbg_state_o
);

    localparam logic [2:0] MCNT_LAST = 3'(MUL_STAGES - 1);

    function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b,
                                                    input logic sgn);
        logic [2*WIDTH-1:0] ea, eb;
        ea = {{WIDTH{sgn & a[WIDTH-1]}}, a};
        eb = {{WIDTH{sgn & b[WIDTH-1]}}, b};
        return ea * eb;
    endfunction

    state_t           state_q;
    logic [WIDTH-1:0] hi_q, lo_q, ma_q, mb_q;
    logic             done_q, busy_q, msgn_q;
    logic [2:0]       mcnt_q;

    logic             accept, sgn, is_div, early_out, div_load, div_last;
    logic [WIDTH-1:0] div_quo, div_rem;
    logic [2*WIDTH-1:0] prod_in, prod_pipe;

    assign accept    = start_i && !cancel_i && (state_q == ST_IDLE);
    assign sgn       = (op_i == OP_MULT) || (op_i == OP_DIV);
    assign is_div    = (op_i == OP_DIV) || (op_i == OP_DIVU);
    assign prod_in   = mul_full(a_i, b_i, sgn);
    assign prod_pipe = mul_full(ma_q, mb_q, msgn_q);

`ifdef MULDIV_EARLY_OUT_EN
    logic [WIDTH-1:0] mag_a, mag_b;
    always_comb begin
        mag_a     = (sgn && a_i[WIDTH-1]) ? -a_i : a_i;
        mag_b     = (sgn && b_i[WIDTH-1]) ? -b_i : b_i;
        early_out = (b_i != '0) && (mag_a < mag_b);
    end
`else
    assign early_out = 1'b0;
`endif

    assign div_load = accept && is_div && !early_out;

    div_core #(.WIDTH(WIDTH)) u_div_core (
        .clk      (clk),
        .rst      (rst),
        .load_i   (div_load),
        .step_i   (state_q == ST_DIV),
        .signed_i (sgn),
        .a_i      (a_i),
        .b_i      (b_i),
        .last_o   (div_last),
        .quo_o    (div_quo),
        .rem_o    (div_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            msgn_q  <= 1'b0;
            mcnt_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        case (op_i)
                            OP_MTHI: hi_q <= a_i;
                            OP_MTLO: lo_q <= a_i;
                            OP_MULT, OP_MULTU: begin
                                if (MUL_STAGES == 1) begin
                                    {hi_q, lo_q} <= prod_in;
                                    done_q       <= 1'b1;
                                end else begin
                                    ma_q    <= a_i;
                                    mb_q    <= b_i;
                                    msgn_q  <= sgn;
                                    mcnt_q  <= 3'd1;
                                    busy_q  <= 1'b1;
                                    state_q <= ST_MUL;
                                end
                            end
                            OP_DIV, OP_DIVU: begin
                                if (early_out) begin
                                    hi_q   <= a_i;
                                    lo_q   <= '0;
                                    done_q <= 1'b1;
                                end else begin
                                    busy_q  <= 1'b1;
                                    state_q <= ST_DIV;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (cancel_i) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (mcnt_q == MCNT_LAST) begin
                        {hi_q, lo_q} <= prod_pipe;
                        done_q       <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= ST_IDLE;
                    end else begin
                        mcnt_q <= mcnt_q + 3'd1;
                    end
                end
                ST_DIV: begin
                    if (cancel_i) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (div_last) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (!cancel_i) begin
                        hi_q   <= div_rem;
                        lo_q   <= div_quo;
                        done_q <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed cases plus random operations against an
// arithmetic reference model. Define MULDIV_EARLY_OUT_EN to match the RTL build.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start_i, cancel_i;
    logic [2:0]   op_i;
    logic [W-1:0] a_i, b_i;
    logic         busy_o, done_o;
    logic [W-1:0] hi_o, lo_o;
    logic [1:0]   dbg_state;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W), .MUL_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .op_i        (op_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .cancel_i    (cancel_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .hi_o        (hi_o),
        .lo_o        (lo_o),
        .dbg_state_o (dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference results straight from the arithmetic definitions.
    task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] eh, output logic [W-1:0] el);
        longint       sa, sb, q, r;
        logic [63:0]  p;
        sa = $signed(a);
        sb = $signed(b);
        eh = m_hi;
        el = m_lo;
        case (op)
            OP_MULT:  begin p = sa * sb; {eh, el} = p; end
            OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; {eh, el} = p; end
            OP_DIV, OP_DIVU: begin
                if (b == 0) begin
                    el = '1;
                    eh = a;
                end else begin
                    if (op == OP_DIVU) begin
                        sa = longint'(a);
                        sb = longint'(b);
                    end
                    q  = sa / sb;
                    r  = sa % sb;
                    el = q[W-1:0];
                    eh = r[W-1:0];
                end
            end
            default: ;
        endcase
    endtask

    function automatic int exp_lat(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint ma, mb;
        if (op == OP_MULT || op == OP_MULTU) return 2;
        ma = (op == OP_DIV) ? longint'($signed(a)) : longint'(a);
        mb = (op == OP_DIV) ? longint'($signed(b)) : longint'(b);
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
`ifdef MULDIV_EARLY_OUT_EN
        if (mb != 0 && ma < mb) return 1;
`endif
        return W + 1;
    endfunction

    // Issue one mul/div and follow it to done_o; optionally keep hammering
    // MTHI requests for 'hold' cycles while it is in flight.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int hold);
        logic [W-1:0] eh, el;
        int           lat, busy_cnt, el_lat;
        logic [W-1:0] hi_before;
        model(op, a, b, eh, el);
        el_lat    = exp_lat(op, a, b);
        hi_before = m_hi;
        op_i = op; a_i = a; b_i = b; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        a_i = $urandom;
        b_i = $urandom;
        lat = 1;
        busy_cnt = 0;
        while (!done_o && lat < 100) begin
            busy_cnt += int'(busy_o);
            start_i = (lat <= hold);
            if (lat <= hold) begin
                op_i = OP_MTHI;
                a_i  = 32'h0000dead;
            end else begin
                a_i = $urandom;
                b_i = $urandom;
            end
            tick();
            lat++;
            if (hold > 0 && lat == hold + 1) check({tag, " hi held"}, hi_o, hi_before);
        end
        start_i = 1'b0;
        check({tag, " latency"}, lat, el_lat);
        check({tag, " busy cycles"}, busy_cnt, el_lat - 1);
        check({tag, " busy at done"}, busy_o, 0);
        check({tag, " hi"}, hi_o, eh);
        check({tag, " lo"}, lo_o, el);
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic run_mt(input string tag, input logic [2:0] op, input logic [W-1:0] a);
        op_i = op; a_i = a; b_i = $urandom; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        if (op == OP_MTHI) m_hi = a; else m_lo = a;
        check({tag, " hi"}, hi_o, m_hi);
        check({tag, " lo"}, lo_o, m_lo);
        check({tag, " no done"}, done_o, 0);
    endtask

    initial begin
        int seen;
        logic [W-1:0] ra, rb;
        logic [2:0]   rop;
        rst = 1'b1; start_i = 1'b0; cancel_i = 1'b0; op_i = OP_MULT; a_i = '0; b_i = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("reset hi", hi_o, 0);
        check("reset lo", lo_o, 0);
        check("reset busy", busy_o, 0);
        check("reset done", done_o, 0);
        check("reset state", dbg_state, 0);

        run_op("mult neg", OP_MULT, 32'hFFFFFFFF, 32'h2, 0);
        run_op("multu", OP_MULTU, 32'hFFFFFFFF, 32'h2, 0);
        run_op("div -7/2", OP_DIV, 32'hFFFFFFF9, 32'h2, 0);
        run_op("divu by 0", OP_DIVU, 32'h7, 32'h0, 0);
        run_op("divu small", OP_DIVU, 32'h3, 32'hA, 0);
        run_op("div ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0);
        run_op("div by 0", OP_DIV, 32'hFFFFFFF9, 32'h0, 0);
        run_op("div 7/-3", OP_DIV, 32'h7, 32'hFFFFFFFD, 0);

        // Cancel a division on its tenth cycle.
        run_mt("mthi 11", OP_MTHI, 32'h11);
        run_mt("mtlo 22", OP_MTLO, 32'h22);
        op_i = OP_DIV; a_i = 32'd100; b_i = 32'd7; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (9) tick();
        check("cancel busy before", busy_o, 1);
        cancel_i = 1'b1;
        tick();
        cancel_i = 1'b0;
        check("cancel busy after", busy_o, 0);
        check("cancel hi", hi_o, 32'h11);
        check("cancel lo", lo_o, 32'h22);
        seen = 0;
        repeat (40) begin
            seen += int'(done_o);
            tick();
        end
        check("cancel no done", seen, 0);
        run_op("after cancel", OP_DIVU, 32'd100, 32'd7, 0);

        // Cancel a multiply in flight.
        op_i = OP_MULT; a_i = 32'd3; b_i = 32'd5; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        cancel_i = 1'b1;
        tick();
        cancel_i = 1'b0;
        check("mul cancel done", done_o, 0);
        check("mul cancel hi", hi_o, m_hi);
        check("mul cancel lo", lo_o, m_lo);

        // MTHI while busy is dropped; MTLO in idle lands after one edge.
        run_op("ignore mthi", OP_DIVU, 32'h12345678, 32'h111, 10);
        run_mt("mtlo abcd", OP_MTLO, 32'hABCD);

        // start and cancel together are not accepted.
        op_i = OP_MTHI; a_i = 32'h55; start_i = 1'b1; cancel_i = 1'b1;
        tick();
        op_i = OP_DIV; a_i = 32'd9; b_i = 32'd2;
        tick();
        start_i = 1'b0; cancel_i = 1'b0;
        check("start+cancel hi", hi_o, m_hi);
        check("start+cancel busy", busy_o, 0);

        // Reset wins over a concurrent start and aborts the operation.
        op_i = OP_DIV; a_i = 32'd1000; b_i = 32'd3; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (5) tick();
        rst = 1'b1; start_i = 1'b1; op_i = OP_MTHI; a_i = 32'h77;
        tick();
        rst = 1'b0; start_i = 1'b0;
        m_hi = '0; m_lo = '0;
        check("mid reset hi", hi_o, 0);
        check("mid reset lo", lo_o, 0);
        check("mid reset busy", busy_o, 0);
        check("mid reset done", done_o, 0);

        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 5));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 4))
                0: rb = '0;
                1: rb = W'($urandom_range(1, 20));
                2: ra = W'($urandom_range(0, 50));
                3: rb = -W'($urandom_range(1, 20));
                default: ;
            endcase
            if (rop == OP_MTHI || rop == OP_MTLO) run_mt("rand mt", rop, ra);
            else run_op("rand op", rop, ra, rb, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
